// File: rtl/x_pixel_gap_filling.sv
// Horizontal gap filler: scans the SRAM image row by row and closes runs of up
// to MAX_GAP pixels lying between two FILL_VALUE pixels in the same row.
module x_pixel_gap_filling #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int SKIP_LINES = 7,
    parameter int MAX_GAP    = 1,
    parameter int FILL_VALUE = 1,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 32
) (
    input  logic              clk_div_by_two,
    input  logic              reset_n,
    input  logic              enable_x_pixel_filling,
    input  logic [DATA_W-1:0] data_read,
    output logic              wren,
    output logic [DATA_W-1:0] data_write,
    output logic [ADDR_W-1:0] address,
    output logic              x_pixel_filling_done,
    output logic [ADDR_W-1:0] fill_count
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int GW = 4;
    localparam int LAST_ROW = IMG_HEIGHT - SKIP_LINES - 1;
    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(SKIP_LINES * IMG_WIDTH);
    localparam logic [DATA_W-1:0] FILL_W     = DATA_W'(FILL_VALUE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [CW-1:0]     last_q, last_d;
    logic              lvld_q, lvld_d;
    logic [GW-1:0]     rem_q, rem_d;
    logic              fin_q, fin_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              hit, row_end, last_px, do_fill, bus_en;
    logic [CW-1:0]     gap;
    logic [ADDR_W-1:0] cnt_inc;

    assign hit     = (data_read == FILL_W);
    assign gap     = col_q - last_q - CW'(1);
    assign do_fill = hit && lvld_q && (gap != '0) && (int'(gap) <= MAX_GAP);
    assign row_end = (col_q == CW'(IMG_WIDTH - 1));
    assign last_px = row_end && (row_q == RW'(LAST_ROW));
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        last_d  = last_q;
        lvld_d  = lvld_q;
        rem_d   = rem_q;
        fin_d   = fin_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        wren_d  = 1'b0;
        wdata_d = '0;
        done_d  = done_q;
        cnt_d   = cnt_q;
        if (!enable_x_pixel_filling) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    row_d   = RW'(SKIP_LINES);
                    col_d   = '0;
                    last_d  = '0;
                    lvld_d  = 1'b0;
                    rem_d   = '0;
                    fin_d   = 1'b0;
                    pix_d   = START_ADDR;
                    addr_d  = START_ADDR;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = S_SCAN;
                end
                S_SCAN: begin
                    // pix_q is the pixel sampled this edge; it always advances,
                    // so after a fill it already names the next scan address.
                    pix_d  = pix_q + ADDR_W'(1);
                    addr_d = pix_q + ADDR_W'(1);
                    col_d  = row_end ? '0 : col_q + CW'(1);
                    if (row_end) row_d = row_q + RW'(1);
                    if (hit) begin
                        last_d = col_q;
                        lvld_d = 1'b1;
                    end
                    if (row_end) lvld_d = 1'b0;
                    fin_d = last_px;
                    if (do_fill) begin
                        state_d = S_FILL;
                        addr_d  = pix_q - ADDR_W'(gap);
                        wren_d  = 1'b1;
                        wdata_d = FILL_W;
                        cnt_d   = cnt_inc;
                        rem_d   = GW'(gap) - GW'(1);
                    end else if (last_px) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
                S_FILL: begin
                    if (rem_q != '0) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        wren_d  = 1'b1;
                        wdata_d = FILL_W;
                        cnt_d   = cnt_inc;
                        rem_d   = rem_q - GW'(1);
                    end else begin
                        addr_d  = pix_q;
                        state_d = fin_q ? S_DONE : S_SCAN;
                        done_d  = fin_q;
                    end
                end
                default: done_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_div_by_two or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= '0;
            lvld_q  <= 1'b0;
            rem_q   <= '0;
            fin_q   <= 1'b0;
            pix_q   <= '0;
            addr_q  <= '0;
            wren_q  <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            last_q  <= last_d;
            lvld_q  <= lvld_d;
            rem_q   <= rem_d;
            fin_q   <= fin_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            wren_q  <= wren_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shared bus: release it the moment reset or enable drops.
    assign bus_en     = reset_n && enable_x_pixel_filling;
    assign wren       = bus_en ? wren_q  : 1'bz;
    assign address    = bus_en ? addr_q  : {ADDR_W{1'bz}};
    assign data_write = bus_en ? wdata_q : {DATA_W{1'bz}};

    assign x_pixel_filling_done = done_q;
    assign fill_count           = cnt_q;

endmodule

// File: tb/tb_x_pixel_gap_filling.sv
// Directed bench for x_pixel_gap_filling on an 8x4 image with one skipped row
// at top and bottom; an image-level model predicts the bus trace and result.
module tb_x_pixel_gap_filling;

    localparam int W = 8, H = 4, SKIP = 1, MG = 2, FV = 1;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic [31:0] data_read;
    wire         wren;
    wire  [31:0] data_write;
    wire  [17:0] address;
    logic        done;
    logic [17:0] fill_count;

    logic [31:0] mem     [32];
    logic [31:0] img     [32];
    logic [31:0] exp_img [32];
    int          exp_a[$];
    bit          exp_w[$];
    int          nf;
    int          checks = 0;
    int          errors = 0;

    x_pixel_gap_filling #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .SKIP_LINES(SKIP), .MAX_GAP(MG),
        .FILL_VALUE(FV), .ADDR_W(18), .DATA_W(32)
    ) dut (
        .clk_div_by_two(clk),
        .reset_n(reset_n),
        .enable_x_pixel_filling(en),
        .data_read(data_read),
        .wren(wren),
        .data_write(data_write),
        .address(address),
        .x_pixel_filling_done(done),
        .fill_count(fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign data_read = mem[address[4:0]];

    always @(posedge clk)
        if (wren === 1'b1) mem[address[4:0]] <= data_write;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 32; i++) img[i] = 32'd0;
    endtask

    // Expected bus trace: one read per scan pixel, followed by the writes of
    // any gap that pixel closes. Decisions use the original image only.
    task automatic build_model();
        exp_a.delete();
        exp_w.delete();
        nf = 0;
        for (int i = 0; i < 32; i++) exp_img[i] = img[i];
        for (int r = SKIP; r < H - SKIP; r++) begin
            int last;
            last = -1;
            for (int c = 0; c < W; c++) begin
                exp_a.push_back(r * W + c);
                exp_w.push_back(1'b0);
                if (img[r * W + c] == 32'(FV)) begin
                    if (last >= 0 && (c - last - 1) >= 1 && (c - last - 1) <= MG) begin
                        for (int k = last + 1; k < c; k++) begin
                            exp_a.push_back(r * W + k);
                            exp_w.push_back(1'b1);
                            exp_img[r * W + k] = 32'(FV);
                            nf++;
                        end
                    end
                    last = c;
                end
            end
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < 32; i++) mem[i] <= img[i];
    endtask

    task automatic start_scan();
        @(negedge clk);
        load_mem();
        build_model();
        en = 1'b1;
    endtask

    task automatic check_scan(input int lit_fc, input int lit_edge);
        int n;
        n = exp_a.size();
        chk("model_done_edge", 64'(n + 1), 64'(lit_edge));
        chk("model_fills", 64'(nf), 64'(lit_fc));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) chk("fc_cleared", 64'(fill_count), 64'd0);
            chk($sformatf("wren_c%0d", i), 64'(wren), 64'(exp_w[i]));
            chk($sformatf("addr_c%0d", i), 64'(address), 64'(exp_a[i]));
            if (exp_w[i]) chk($sformatf("wdata_c%0d", i), 64'(data_write), 64'(FV));
            chk($sformatf("done_low_c%0d", i), 64'(done), 64'd0);
        end
        @(negedge clk);
        chk("done", 64'(done), 64'd1);
        chk("done_wren", 64'(wren), 64'd0);
        chk("fill_count", 64'(fill_count), 64'(nf));
        chk("fill_count_lit", 64'(fill_count), 64'(lit_fc));
        for (int i = 0; i < 32; i++)
            chk($sformatf("mem%0d", i), 64'(mem[i]), 64'(exp_img[i]));
        @(negedge clk);
        chk("done_hold", 64'(done), 64'd1);
    endtask

    task automatic stop_scan();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("done_clr", 64'(done), 64'd0);
        chk("fc_held", 64'(fill_count), 64'(nf));
    endtask

    initial begin
        bit seen;
        reset_n = 1'b0;
        en      = 1'b0;
        clear_img();
        load_mem();
        repeat (2) @(negedge clk);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fc", 64'(fill_count), 64'd0);
        chk("rst_wren_z", 64'(wren === 1'b1), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_done", 64'(done), 64'd0);

        // empty image
        clear_img();
        start_scan(); check_scan(0, 17); stop_scan();
        // small gap
        clear_img(); img[8] = 1; img[11] = 1;
        start_scan(); check_scan(2, 19); stop_scan();
        // gap of 3 ignored, adjacent hits
        clear_img(); img[8] = 1; img[12] = 1; img[13] = 1;
        start_scan(); check_scan(0, 17); stop_scan();
        // no bridging across rows
        clear_img(); img[14] = 1; img[17] = 1;
        start_scan(); check_scan(0, 17); stop_scan();
        // gap closed by the final pixel
        clear_img(); img[20] = 1; img[23] = 1;
        start_scan(); check_scan(2, 19); stop_scan();
        // non-marker word inside a gap is overwritten
        clear_img(); img[8] = 1; img[9] = 2; img[10] = 1;
        start_scan(); check_scan(1, 18); stop_scan();

        // enable dropped during a fill
        clear_img(); img[8] = 1; img[11] = 1;
        start_scan();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (wren === 1'b1) seen = 1'b1;
        end
        chk("fill_reached", 64'(seen), 64'd1);
        en = 1'b0;
        #1;
        chk("drop_wren_z", 64'(wren === 1'b1), 64'd0);
        chk("drop_wdata_z", 64'(data_write === 32'(FV)), 64'd0);
        @(negedge clk);
        chk("drop_done", 64'(done), 64'd0);
        chk("drop_fc_held", 64'(fill_count), 64'd1);
        @(negedge clk);
        chk("drop_idle_done", 64'(done), 64'd0);
        // full rescan after re-enable
        start_scan(); check_scan(2, 19); stop_scan();

        // reset pulsed mid-scan, restart on release with enable held
        clear_img(); img[8] = 1; img[11] = 1;
        start_scan();
        repeat (10) @(negedge clk);
        chk("pre_rst_fc", 64'(fill_count), 64'd2);
        reset_n = 1'b0;
        #1;
        chk("arst_fc", 64'(fill_count), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_addr_z", 64'(address === 18'd18), 64'd0);
        @(negedge clk);
        load_mem();
        build_model();
        reset_n = 1'b1;
        check_scan(2, 19);
        stop_scan();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
